// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-port signals shared by the arbiter and its environment
interface mem_port_arbiter_if #(parameter int WORD_SIZE = 16);
  logic                 if_req, if_done, d_req, d_we, d_done;
  logic                 mem_readM, mem_writeM, mem_ack, busy, timeout_err;
  logic [WORD_SIZE-1:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [WORD_SIZE-1:0] mem_addr, mem_wdata, mem_rdata;
  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_done, if_rdata, d_done, d_rdata, mem_readM, mem_writeM, mem_addr, mem_wdata,
           busy, timeout_err
  );
  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_done, if_rdata, d_done, d_rdata, mem_readM, mem_writeM, mem_addr, mem_wdata,
           busy, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters with a watchdog
module mem_port_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int TIMEOUT   = 64
) (
  input logic                clk,
  input logic                reset_n,
  mem_port_arbiter_if.master bus
);
  localparam logic [15:0] LIM = 16'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, FETCH, DLOAD, DSTORE, DONE} state_t;
  state_t               state, state_nx;
  logic [15:0]          cnt, cnt_nx;
  logic                 last_d, last_nx, err, err_nx;
  logic [WORD_SIZE-1:0] addr, addr_nx, wdata, wdata_nx;
  logic [WORD_SIZE-1:0] if_rd, if_rd_nx, d_rd, d_rd_nx;
  logic                 abort, fin, grant_f;
  assign abort   = !bus.mem_ack && cnt == LIM;
  assign fin     = bus.mem_ack || abort;
  assign grant_f = bus.if_req && (!bus.d_req || last_d);
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last_d;
    err_nx   = err;
    addr_nx  = addr;
    wdata_nx = wdata;
    if_rd_nx = if_rd;
    d_rd_nx  = d_rd;
    unique case (state)
      IDLE: begin
        if (grant_f) begin
          state_nx = FETCH;
          addr_nx  = bus.if_addr;
          cnt_nx   = '0;
        end else if (bus.d_req) begin
          state_nx = bus.d_we ? DSTORE : DLOAD;
          addr_nx  = bus.d_addr;
          wdata_nx = bus.d_we ? bus.d_wdata : wdata;
          cnt_nx   = '0;
        end
      end
      FETCH, DLOAD, DSTORE: begin
        if (fin) begin
          state_nx = DONE;
          last_nx  = state != FETCH;
          err_nx   = err | abort;
          if_rd_nx = state == FETCH ? (bus.mem_ack ? bus.mem_rdata : '0) : if_rd;
          d_rd_nx  = state == DLOAD ? (bus.mem_ack ? bus.mem_rdata : '0) : d_rd;
        end else
          cnt_nx = cnt + 16'd1;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      last_d <= 1'b1;
      err    <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      if_rd  <= '0;
      d_rd   <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      last_d <= last_nx;
      err    <= err_nx;
      addr   <= addr_nx;
      wdata  <= wdata_nx;
      if_rd  <= if_rd_nx;
      d_rd   <= d_rd_nx;
    end
  end
  assign bus.mem_readM   = state == FETCH || state == DLOAD;
  assign bus.mem_writeM  = state == DSTORE;
  assign bus.if_done     = state == DONE && !last_d;
  assign bus.d_done      = state == DONE && last_d;
  assign bus.busy        = state != IDLE;
  assign bus.timeout_err = err;
  assign bus.mem_addr    = addr;
  assign bus.mem_wdata   = wdata;
  assign bus.if_rdata    = if_rd;
  assign bus.d_rdata     = d_rd;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, handshake, watchdog and reset
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  mem_port_arbiter_if #(.WORD_SIZE(16)) a ();
  mem_port_arbiter_if #(.WORD_SIZE(16)) b ();
  mem_port_arbiter #(.WORD_SIZE(16), .TIMEOUT(8)) u_a (.clk(clk), .reset_n(reset_n), .bus(a.master));
  mem_port_arbiter #(.WORD_SIZE(16), .TIMEOUT(4)) u_b (.clk(clk), .reset_n(reset_n), .bus(b.master));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    {a.if_req, a.d_req, a.d_we, a.mem_ack} = '0;
    {a.if_addr, a.d_addr, a.d_wdata, a.mem_rdata} = '0;
    {b.if_req, b.d_req, b.d_we, b.mem_ack} = '0;
    {b.if_addr, b.d_addr, b.d_wdata, b.mem_rdata} = '0;
    tick();
    tick();
    check("rst_busy", 16'(a.busy), 16'd0);
    check("rst_strobes", {14'd0, a.mem_readM, a.mem_writeM}, 16'd0);
    check("rst_dones", {14'd0, a.if_done, a.d_done}, 16'd0);
    check("rst_if_rdata", a.if_rdata, 16'h0000);
    check("rst_d_rdata", a.d_rdata, 16'h0000);
    check("rst_addr", a.mem_addr, 16'h0000);
    check("rst_wdata", a.mem_wdata, 16'h0000);
    check("rst_err", 16'(a.timeout_err), 16'd0);
    reset_n = 1'b1;
    tick();
    a.if_req  = 1'b1;
    a.if_addr = 16'h0010;
    tick();
    check("f_read1", 16'(a.mem_readM), 16'd1);
    check("f_addr", a.mem_addr, 16'h0010);
    check("f_busy", 16'(a.busy), 16'd1);
    tick();
    check("f_read2", 16'(a.mem_readM), 16'd1);
    tick();
    check("f_read3", 16'(a.mem_readM), 16'd1);
    check("f_nodone", 16'(a.if_done), 16'd0);
    a.mem_ack   = 1'b1;
    a.mem_rdata = 16'hF01C;
    tick();
    check("f_done", 16'(a.if_done), 16'd1);
    check("f_rdata", a.if_rdata, 16'hF01C);
    check("f_read_off", 16'(a.mem_readM), 16'd0);
    a.mem_ack = 1'b0;
    a.if_req  = 1'b0;
    tick();
    check("f_idle_busy", 16'(a.busy), 16'd0);
    check("f_done_off", 16'(a.if_done), 16'd0);
    a.d_req   = 1'b1;
    a.d_we    = 1'b1;
    a.d_addr  = 16'h0040;
    a.d_wdata = 16'hBEEF;
    tick();
    check("s_write", 16'(a.mem_writeM), 16'd1);
    check("s_noread", 16'(a.mem_readM), 16'd0);
    check("s_addr", a.mem_addr, 16'h0040);
    check("s_wdata", a.mem_wdata, 16'hBEEF);
    a.mem_ack   = 1'b1;
    a.mem_rdata = 16'h5555;
    tick();
    check("s_done", 16'(a.d_done), 16'd1);
    check("s_write_off", 16'(a.mem_writeM), 16'd0);
    check("s_noread2", 16'(a.mem_readM), 16'd0);
    check("s_d_rdata", a.d_rdata, 16'h0000);
    check("s_if_done", 16'(a.if_done), 16'd0);
    a.mem_ack = 1'b0;
    a.d_req   = 1'b0;
    a.d_we    = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n   = 1'b1;
    a.if_req  = 1'b1;
    a.if_addr = 16'h0100;
    a.d_req   = 1'b1;
    a.d_addr  = 16'h0080;
    for (int k = 0; k < 8; k++) begin
      logic ef;
      ef = (k % 2) == 0;
      tick();
      check("p_read", 16'(a.mem_readM), 16'd1);
      check("p_addr", a.mem_addr, ef ? 16'h0100 : 16'h0080);
      a.mem_ack   = 1'b1;
      a.mem_rdata = 16'hA000 + 16'(k);
      tick();
      check("p_if_done", 16'(a.if_done), 16'(ef));
      check("p_d_done", 16'(a.d_done), 16'(!ef));
      check("p_rdata", ef ? a.if_rdata : a.d_rdata, 16'hA000 + 16'(k));
      a.mem_ack = 1'b0;
      if (ef) a.if_req = 1'b0;
      else a.d_req = 1'b0;
      tick();
      a.if_req = 1'b1;
      a.d_req  = 1'b1;
    end
    a.if_req = 1'b0;
    a.d_addr = 16'h0200;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("t_read", 16'(a.mem_readM), 16'd1);
      check("t_noerr", 16'(a.timeout_err), 16'd0);
      tick();
    end
    check("t_read_off", 16'(a.mem_readM), 16'd0);
    check("t_done", 16'(a.d_done), 16'd1);
    check("t_rdata", a.d_rdata, 16'h0000);
    check("t_err", 16'(a.timeout_err), 16'd1);
    a.d_req = 1'b0;
    tick();
    check("t_idle", 16'(a.busy), 16'd0);
    tick();
    check("t_sticky", 16'(a.timeout_err), 16'd1);
    b.if_req  = 1'b1;
    b.if_addr = 16'h0300;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("l_read", 16'(b.mem_readM), 16'd1);
      tick();
    end
    check("l_read4", 16'(b.mem_readM), 16'd1);
    b.mem_ack   = 1'b1;
    b.mem_rdata = 16'h1234;
    tick();
    check("l_done", 16'(b.if_done), 16'd1);
    check("l_rdata", b.if_rdata, 16'h1234);
    check("l_noerr", 16'(b.timeout_err), 16'd0);
    b.mem_ack = 1'b0;
    b.if_req  = 1'b0;
    tick();
    a.if_req  = 1'b1;
    a.if_addr = 16'h0010;
    tick();
    tick();
    check("r_read_pre", 16'(a.mem_readM), 16'd1);
    reset_n = 1'b0;
    tick();
    check("r_read", 16'(a.mem_readM), 16'd0);
    check("r_busy", 16'(a.busy), 16'd0);
    check("r_done", 16'(a.if_done), 16'd0);
    check("r_err_clr", 16'(a.timeout_err), 16'd0);
    reset_n   = 1'b1;
    a.if_req  = 1'b0;
    a.mem_ack = 1'b1;
    tick();
    check("r_late_dones", {14'd0, a.if_done, a.d_done}, 16'd0);
    check("r_late_busy", 16'(a.busy), 16'd0);
    tick();
    check("r_late_dones2", {14'd0, a.if_done, a.d_done}, 16'd0);
    check("r_late_rdata", a.if_rdata, 16'h0000);
    a.mem_ack = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  always @(negedge clk) begin
    if (a.mem_readM && a.mem_writeM) begin
      checks++;
      failures++;
      $display("FAIL strobe_excl: readM=%b writeM=%b required not both 1", a.mem_readM, a.mem_writeM);
    end
  end
endmodule
